ram_16bit: RTL and testbench

Single-port synchronous RAM: 16 words × 16 bits, one shared address bus, registered read port. It is a small scratch/storage block for datapath logic that needs a register file. Reset clears every location. All state changes on the rising edge of `clk`.

---
 rtl/ram_16bit.sv | 33 +++
 tb/tb_ram_16bit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ram_16bit.sv
// Single-port synchronous RAM with a registered read port.
// A synchronous reset clears every word and the output register.
module ram_16bit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Writes leave data_out untouched; reads see the pre-edge array contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else if (write_data) begin
            mem[address] <= data_in;
        end else begin
            data_out <= mem[address];
        end
    end

endmodule

// File: tb/tb_ram_16bit.sv
// Directed self-checking bench for ram_16bit: reset clear, fill/read-back
// patterns, per-address data, output hold during writes and reset mid-write.
module tb_ram_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_data;
    logic [15:0] data_in;
    logic [3:0]  address;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    ram_16bit #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_data (write_data),
        .data_in    (data_in),
        .address    (address),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] expected);
        n_checks++;
        assert (data_out === expected) else begin
            n_fail++;
            $error("FAIL %s: data_out=%h expected=%h", tag, data_out, expected);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        write_data = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        write_data = 1'b1;
        address    = a;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] expected, input string tag);
        write_data = 1'b0;
        address    = a;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    logic [15:0] patterns [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

    initial begin
        rst        = 1'b0;
        write_data = 1'b0;
        data_in    = '0;
        address    = '0;

        // Reset clear
        @(posedge clk);
        #1;
        check("power_up_reset", 16'h0000);
        rst = 1'b1;
        for (int a = 0; a < 16; a++) do_write(4'(a), 16'hFFFF);
        check("hold_during_fill", 16'h0000);
        do_read(4'd9, 16'hFFFF, "ffff_before_reset");
        do_reset();
        check("out_after_reset", 16'h0000);
        for (int a = 0; a < 16; a++) do_read(4'(a), 16'h0000, "reset_clear");

        // Successive patterns with reset before each
        for (int p = 0; p < 4; p++) begin
            do_reset();
            do_read(4'd0, 16'h0000, "read_after_reset");
            for (int a = 0; a < 16; a++) do_write(4'(a), patterns[p]);
            for (int a = 0; a < 16; a++) do_read(4'(a), patterns[p], "pattern_readback");
        end

        // Distinct data per address, read in reverse order
        do_reset();
        for (int a = 0; a < 16; a++) do_write(4'(a), 16'(a) ^ 16'hA5A5);
        for (int a = 15; a >= 0; a--) do_read(4'(a), 16'(a) ^ 16'hA5A5, "distinct_reverse");

        // Write holds output; no write-through
        do_write(4'd3, 16'h1234);
        do_read(4'd3, 16'h1234, "read_addr3");
        address = 4'd7;
        #3;
        check("addr_change_between_edges", 16'h1234);
        do_write(4'd3, 16'hBEEF);
        check("hold_during_write", 16'h1234);
        do_read(4'd3, 16'hBEEF, "readback_beef");
        do_read(4'd7, 16'h0007 ^ 16'hA5A5, "neighbour_intact");

        // Reset on the same edge as a write
        rst        = 1'b0;
        write_data = 1'b1;
        address    = 4'd5;
        data_in    = 16'h5555;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("out_after_reset_mid_write", 16'h0000);
        do_read(4'd5, 16'h0000, "reset_mid_write_addr5");
        do_read(4'd3, 16'h0000, "reset_mid_write_addr3");

        // First edge after reset release performs a normal write
        do_write(4'd5, 16'h5555);
        do_read(4'd5, 16'h5555, "write_after_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
